// File: rtl/exec_alu_muldiv.sv
// exec_alu_muldiv: execute-stage ALU with ALUOp/funct decode, plus an iterative
// multiply/divide engine owning the architectural HI/LO registers.
//
// Optional feature macro: EXEC_MULDIV_EN
//   defined   -> mult/div engine, HI/LO registers and stall logic are built
//   undefined -> hi/lo/busy/stall_req/div_zero tie to 0, HI/LO ops decode illegal
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   valid_in          instruction present in EX
//   ALUOp, funct      operation select (ALUOp=10 uses funct)
//   op_a, op_b        rs/rt operands after forwarding
//   result, zero      combinational result and result==0 flag
//   illegal_op        valid_in with an undefined funct
//   stall_req         HI/LO-class op presented while the engine is busy
//   busy              engine iterating (registered state)
//   div_zero          one-cycle pulse during the FIX cycle of a divide by zero
//   hi, lo            architectural HI/LO
module exec_alu_muldiv #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              illegal_op,
  output logic              stall_req,
  output logic              busy,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
  localparam int unsigned PW    = 2 * DATA_W;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
    OP_ILL
  } op_e;

  op_e               w_op;
  logic [DATA_W-1:0] w_hi_rd;
  logic [DATA_W-1:0] w_lo_rd;

  // Operation decode
  always_comb begin
    w_op = OP_ILL;
    unique case (ALUOp)
      2'b00: w_op = OP_ADD;
      2'b01: w_op = OP_SUB;
      2'b11: w_op = OP_OR;
      default: begin
        case (funct)
          6'b100000, 6'b100001: w_op = OP_ADD;
          6'b100010, 6'b100011: w_op = OP_SUB;
          6'b100100:            w_op = OP_AND;
          6'b100101:            w_op = OP_OR;
          6'b100110:            w_op = OP_XOR;
          6'b100111:            w_op = OP_NOR;
          6'b101010:            w_op = OP_SLT;
          6'b101011:            w_op = OP_SLTU;
`ifdef EXEC_MULDIV_EN
          6'b010000:            w_op = OP_MFHI;
          6'b010010:            w_op = OP_MFLO;
          6'b010001:            w_op = OP_MTHI;
          6'b010011:            w_op = OP_MTLO;
          6'b011000:            w_op = OP_MULT;
          6'b011001:            w_op = OP_MULTU;
          6'b011010:            w_op = OP_DIV;
          6'b011011:            w_op = OP_DIVU;
`endif
          default:              w_op = OP_ILL;
        endcase
      end
    endcase
  end

  // Single-cycle datapath
  always_comb begin
    result = '0;
    case (w_op)
      OP_ADD:  result = op_a + op_b;
      OP_SUB:  result = op_a - op_b;
      OP_AND:  result = op_a & op_b;
      OP_OR:   result = op_a | op_b;
      OP_XOR:  result = op_a ^ op_b;
      OP_NOR:  result = ~(op_a | op_b);
      OP_SLT:  result = DATA_W'($signed(op_a) < $signed(op_b));
      OP_SLTU: result = DATA_W'(op_a < op_b);
      OP_MFHI: result = w_hi_rd;
      OP_MFLO: result = w_lo_rd;
      default: result = '0;
    endcase
  end

  assign zero       = (result == '0);
  assign illegal_op = valid_in & (w_op == OP_ILL);

`ifdef EXEC_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_hi, r_lo;
  logic [DATA_W-1:0] r_acc;     // product high half / partial remainder
  logic [DATA_W-1:0] r_q;       // multiplier->product low half / dividend->quotient
  logic [DATA_W-1:0] r_b;       // multiplicand / divisor magnitude
  logic [DATA_W-1:0] r_a_raw;   // raw dividend, reported in HI on divide by zero
  logic              r_is_div, r_neg_q, r_neg_r, r_b_zero, r_div_zero;

  logic              w_hilo_class, w_accept, w_signed, w_a_neg, w_b_neg;
  logic [DATA_W-1:0] w_a_mag, w_b_mag;
  logic [DATA_W:0]   w_mul_sum, w_div_shift, w_div_sub;
  logic              w_div_ge;
  logic [PW-1:0]     w_prod, w_prod_fix;

  assign w_hilo_class = (w_op == OP_MFHI) || (w_op == OP_MFLO) || (w_op == OP_MTHI) ||
                        (w_op == OP_MTLO) || (w_op == OP_MULT) || (w_op == OP_MULTU) ||
                        (w_op == OP_DIV)  || (w_op == OP_DIVU);
  assign w_accept = valid_in & (r_state == S_IDLE);

  assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
  assign w_a_neg  = w_signed & op_a[DATA_W-1];
  assign w_b_neg  = w_signed & op_b[DATA_W-1];
  assign w_a_mag  = w_a_neg ? DATA_W'('0 - op_a) : op_a;
  assign w_b_mag  = w_b_neg ? DATA_W'('0 - op_b) : op_b;

  // Shift-add step: conditional add into the high half, then shift the pair right
  assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);

  // Restoring step: no borrow (MSB clear) means the trial subtraction fits
  assign w_div_shift = {r_acc, r_q[DATA_W-1]};
  assign w_div_sub   = w_div_shift - {1'b0, r_b};
  assign w_div_ge    = ~w_div_sub[DATA_W];

  assign w_prod     = {r_acc, r_q};
  assign w_prod_fix = r_neg_q ? PW'('0 - w_prod) : w_prod;

  // Engine FSM, counter and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_acc      <= '0;
      r_q        <= '0;
      r_b        <= '0;
      r_a_raw    <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_b_zero   <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= w_a_mag;
            r_b      <= w_b_mag;
            r_a_raw  <= op_a;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_b_zero <= (op_b == '0);
            case (w_op)
              OP_MTHI: r_hi <= op_a;
              OP_MTLO: r_lo <= op_a;
              OP_MULT, OP_MULTU: begin
                r_is_div <= 1'b0;
                r_state  <= S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                r_is_div <= 1'b1;
                r_state  <= S_DIV;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          r_acc <= w_mul_sum[DATA_W:1];
          r_q   <= {w_mul_sum[0], r_q[DATA_W-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DATA_W - 1)) r_state <= S_FIX;
        end
        S_DIV: begin
          r_acc <= w_div_ge ? w_div_sub[DATA_W-1:0] : w_div_shift[DATA_W-1:0];
          r_q   <= {r_q[DATA_W-2:0], w_div_ge};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DATA_W - 1)) begin
            r_state    <= S_FIX;
            r_div_zero <= r_b_zero;
          end
        end
        default: begin
          if (!r_is_div) begin
            r_hi <= w_prod_fix[PW-1:DATA_W];
            r_lo <= w_prod_fix[DATA_W-1:0];
          end else if (r_b_zero) begin
            r_hi <= r_a_raw;
            r_lo <= '1;
          end else begin
            r_hi <= r_neg_r ? DATA_W'('0 - r_acc) : r_acc;
            r_lo <= r_neg_q ? DATA_W'('0 - r_q) : r_q;
          end
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign stall_req = valid_in & w_hilo_class & busy;
  assign div_zero  = r_div_zero;
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign w_hi_rd   = r_hi;
  assign w_lo_rd   = r_lo;
`else
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, clk, rst_n};

  assign busy      = 1'b0;
  assign stall_req = 1'b0;
  assign div_zero  = 1'b0;
  assign hi        = '0;
  assign lo        = '0;
  assign w_hi_rd   = '0;
  assign w_lo_rd   = '0;
`endif

endmodule

// File: tb/tb_exec_alu_muldiv.sv
// Directed testbench for exec_alu_muldiv (DATA_W=32). Covers whichever build
// (EXEC_MULDIV_EN defined or not) it is compiled with.
module tb_exec_alu_muldiv;

  localparam int unsigned W = 32;

  logic          clk;
  logic          rst_n;
  logic          valid_in;
  logic [1:0]    ALUOp;
  logic [5:0]    funct;
  logic [W-1:0]  op_a, op_b;
  logic [W-1:0]  result;
  logic          zero, illegal_op, stall_req, busy, div_zero;
  logic [W-1:0]  hi, lo;

  int n_total = 0;
  int n_bad   = 0;

  exec_alu_muldiv #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ALUOp(ALUOp), .funct(funct),
    .op_a(op_a), .op_b(op_b), .result(result), .zero(zero), .illegal_op(illegal_op),
    .stall_req(stall_req), .busy(busy), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] aop, input logic [5:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    valid_in = v; ALUOp = aop; funct = fn; op_a = a; op_b = b;
    #1;
  endtask

  // Issue one op for the accept edge, then idle and count busy / div_zero cycles
  task automatic run_long(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int n_busy, output int n_dz);
    @(negedge clk);
    drive(1'b1, 2'b10, fn, a, b);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 2'b00, 6'd0, '0, '0);
    n_busy = 0;
    n_dz   = 0;
    while (busy && n_busy < 200) begin
      n_busy++;
      if (div_zero) n_dz++;
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    int nb, nd, ns;
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 6'd0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    rst_n = 1'b1;

    // Single-cycle ops
    @(negedge clk);
    drive(1'b1, 2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1);
    chk("slt", 64'(result), 64'd1);
    chk("slt_zero", 64'(zero), 64'd0);
    drive(1'b1, 2'b10, 6'b101011, 32'hFFFF_FFFF, 32'd1);
    chk("sltu", 64'(result), 64'd0);
    chk("sltu_zero", 64'(zero), 64'd1);
    drive(1'b1, 2'b00, 6'd0, 32'd2, 32'd3);
    chk("aluop_add", 64'(result), 64'd5);
    drive(1'b1, 2'b01, 6'd0, 32'd3, 32'd5);
    chk("aluop_sub", 64'(result), 64'hFFFF_FFFE);
    drive(1'b1, 2'b11, 6'd0, 32'h00F0, 32'h0F0F);
    chk("aluop_or", 64'(result), 64'h0FFF);
    drive(1'b1, 2'b10, 6'b100001, 32'hFFFF_FFFF, 32'd1);
    chk("addu_wrap", 64'(result), 64'd0);
    chk("addu_zero", 64'(zero), 64'd1);
    drive(1'b1, 2'b10, 6'b100100, 32'hFF00_FF00, 32'h0FF0_0FF0);
    chk("and", 64'(result), 64'h0F00_0F00);
    drive(1'b1, 2'b10, 6'b100110, 32'hFF00_FF00, 32'h0FF0_0FF0);
    chk("xor", 64'(result), 64'hF0F0_F0F0);
    drive(1'b1, 2'b10, 6'b100111, 32'hFF00_FF00, 32'h0FF0_0FF0);
    chk("nor", 64'(result), 64'h000F_000F);
    drive(1'b1, 2'b10, 6'b100010, 32'h8000_0000, 32'd1);
    chk("sub_wrap", 64'(result), 64'h7FFF_FFFF);
    drive(1'b1, 2'b10, 6'b111111, 32'd4, 32'd5);
    chk("undef_ill", 64'(illegal_op), 64'd1);
    chk("undef_res", 64'(result), 64'd0);
    drive(1'b0, 2'b10, 6'b111111, 32'd4, 32'd5);
    chk("undef_noval", 64'(illegal_op), 64'd0);
    drive(1'b1, 2'b10, 6'b100000, 32'd4, 32'd5);
    chk("add_legal", 64'(illegal_op), 64'd0);

`ifdef EXEC_MULDIV_EN
    run_long(6'b011000, 32'hFFFF_FFFD, 32'd7, nb, nd);
    chk("mult_busy", 64'(nb), 64'd33);
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);

    run_long(6'b011010, 32'hFFFF_FFF9, 32'd2, nb, nd);
    chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("div_dz_none", 64'(nd), 64'd0);

    run_long(6'b011011, 32'd9, 32'd0, nb, nd);
    chk("divz_lo", 64'(lo), 64'hFFFF_FFFF);
    chk("divz_hi", 64'(hi), 64'd9);
    chk("divz_pulse", 64'(nd), 64'd1);
    chk("divz_after", 64'(div_zero), 64'd0);

    run_long(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, nb, nd);
    chk("minneg1_lo", 64'(lo), 64'h8000_0000);
    chk("minneg1_hi", 64'(hi), 64'd0);

    // MTHI/MTLO then MFHI/MFLO
    @(negedge clk);
    drive(1'b1, 2'b10, 6'b010001, 32'h1234_5678, 32'd0);
    @(posedge clk); @(negedge clk);
    drive(1'b1, 2'b10, 6'b010011, 32'h0BAD_F00D, 32'd0);
    @(posedge clk); @(negedge clk);
    drive(1'b1, 2'b10, 6'b010000, 32'd0, 32'd0);
    chk("mthi_mfhi", 64'(result), 64'h1234_5678);
    drive(1'b1, 2'b10, 6'b010010, 32'd0, 32'd0);
    chk("mtlo_mflo", 64'(result), 64'h0BAD_F00D);

    // MULTU 6x7, interleaved ADD, then MFLO stalled until completion
    drive(1'b1, 2'b10, 6'b011001, 32'd6, 32'd7);
    @(posedge clk); @(negedge clk);
    drive(1'b1, 2'b10, 6'b100000, 32'd2, 32'd3);
    chk("intlv_add", 64'(result), 64'd5);
    chk("intlv_nostall", 64'(stall_req), 64'd0);
    @(posedge clk); @(negedge clk);
    drive(1'b1, 2'b10, 6'b010010, 32'd0, 32'd0);
    ns = 0;
    while (stall_req && ns < 200) begin
      ns++;
      @(negedge clk);
      #1;
    end
    chk("mflo_stall_cnt", 64'(ns), 64'd32);
    chk("mflo_result", 64'(result), 64'd42);
    drive(1'b1, 2'b10, 6'b010000, 32'd0, 32'd0);
    chk("mfhi_result", 64'(result), 64'd0);
    drive(1'b0, 2'b00, 6'd0, '0, '0);

    // Reset in the middle of a divide
    @(negedge clk);
    drive(1'b1, 2'b10, 6'b011011, 32'd100, 32'd7);
    @(posedge clk); @(negedge clk);
    drive(1'b0, 2'b00, 6'd0, '0, '0);
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_long(6'b011001, 32'd2, 32'd2, nb, nd);
    chk("post_rst_lo", 64'(lo), 64'd4);
    chk("post_rst_hi", 64'(hi), 64'd0);
`else
    @(negedge clk);
    drive(1'b1, 2'b10, 6'b011000, 32'hFFFF_FFFD, 32'd7);
    chk("dis_mult_ill", 64'(illegal_op), 64'd1);
    chk("dis_mult_res", 64'(result), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("dis_busy", 64'(busy), 64'd0);
    drive(1'b1, 2'b10, 6'b010000, 32'd0, 32'd0);
    chk("dis_mfhi_ill", 64'(illegal_op), 64'd1);
    chk("dis_stall", 64'(stall_req), 64'd0);
    drive(1'b1, 2'b10, 6'b010001, 32'h55, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("dis_hi", 64'(hi), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/exec_alu_muldiv.md
# exec_alu_muldiv

Execute-stage arithmetic unit for the pipelined MIPS core, and the parametrised successor of the 2-bit ALUOp/funct ALU control decoder. It decodes ALUOp and funct into an ALU operation and computes single-cycle results combinationally. It also runs an iterative multiply/divide engine with architectural HI/LO registers. While that engine is busy, the unit raises a stall request toward the hazard unit for any dependent instruction.

## Interface
- DATA_W, 32: operand/result width; even, ≥ 4.
- CNT_W, $clog2(DATA_W)+1: iteration counter width (derived, not overridden).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  instruction present in EX this cycle.
- ALUOp  in  2  00 ADD, 01 SUB, 10 use funct, 11 OR (immediate logical).
- funct  in  6  R-type function field.
- op_a, op_b  in  DATA_W  rs/rt operands (post-forwarding).
- result  out  DATA_W  combinational result.
- zero  out  1  result == 0.
- illegal_op  out  1  valid_in with undefined funct under ALUOp=10.
- stall_req  out  1  hold EX and earlier stages this cycle.
- busy  out  1  mult/div engine iterating.
- div_zero  out  1  one-cycle pulse at completion of a divide by zero.
- hi, lo  out  DATA_W  architectural HI/LO.

## Operation
- ALUOp=10 funct decode:
  - 100000/100001 ADD/ADDU; 100010/100011 SUB/SUBU.
  - 100100 AND; 100101 OR; 100110 XOR; 100111 NOR.
  - 101010 SLT (signed); 101011 SLTU.
  - 010000 MFHI; 010010 MFLO; 010001 MTHI; 010011 MTLO.
  - 011000 MULT; 011001 MULTU; 011010 DIV; 011011 DIVU.
- Arithmetic and overflow:
  - All add/sub wrap modulo 2^DATA_W. No overflow trap.
  - SLT/SLTU produce zero-extended 0 or 1.
- Undefined funct: result=0, illegal_op=valid_in, no state change.
- result=0 for MTHI/MTLO/MULT*/DIV*.
- Ops touching HI/LO (MF*, MT*, MULT*, DIV*) are HI/LO-class.
- stall_req = valid_in & HI/LO-class & busy. Non-HI/LO ops never stall.
- Accept condition: valid_in & !busy.
  - MTHI/MTLO write op_a to hi/lo at that edge.
  - MFHI/MFLO read current hi/lo combinationally.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE → MUL on accepted MULT*; IDLE → DIV on accepted DIV*.
  - At accept, capture operand magnitudes (signed ops take absolute values) and the result sign.
  - MUL: radix-2 shift-add for DATA_W cycles.
  - DIV: restoring divide for DATA_W cycles.
  - MUL/DIV → FIX when the counter hits DATA_W−1.
  - FIX: apply sign, write hi/lo, → IDLE.
- Sign fix:
  - Signed MULT: negate the 2·DATA_W product if signs differ.
  - Signed DIV: quotient negative if signs differ; remainder takes the dividend's sign.
- Divide by zero: lo = all ones, hi = op_a as captured (raw, no sign fix), div_zero pulses in FIX.
- Signed MIN / −1: lo = MIN, hi = 0 (natural wrap).
- busy = (state != IDLE).

## Timing
- Reset (async, immediate): state=IDLE, busy=0, div_zero=0, hi=lo=0, counter=0. A mult/div in flight is abandoned; hi/lo stay 0.
- Single-cycle ops: result, zero, illegal_op and stall_req are combinational, 0 cycles latency.
- Mult/div accepted at edge T:
  - busy=1 from T+1 through T+DATA_W+1.
  - hi/lo updated at edge T+DATA_W+1.
  - busy=0 after that edge.
  - Total latency DATA_W+1 cycles.
- An op issued in the cycle after completion sees the new hi/lo, with no stall.
- A HI/LO-class op presented while busy is not accepted. It is held by stall_req until busy falls, then accepted that cycle.
- MTHI/MTLO at the same edge as the FIX write cannot occur, because the stall blocks it.

## Configuration
- EXEC_MULDIV_EN defined: behaviour as above.
- EXEC_MULDIV_EN undefined:
  - FSM, counter and HI/LO logic are not compiled.
  - hi=lo=0, busy=0, stall_req=0, div_zero=0.
  - MF*/MT*/MULT*/DIV* decode as undefined: illegal_op=valid_in, result=0.

## Test plan
- DATA_W=32, ALUOp=10, funct 101010, op_a=0xFFFFFFFF, op_b=1 → result=1. With funct 101011 → result=0, zero=1.
- MULT op_a=−3, op_b=7 → busy for exactly 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV op_a=−7, op_b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU op_a=9, op_b=0 → lo=0xFFFFFFFF, hi=9, div_zero pulse one cycle.
- MFLO issued 1 cycle after MULTU 6×7 → stall_req high 32 cycles, then result=42. An interleaved ADD 2+3 during busy → result=5, stall_req=0.
- rst_n low mid-DIV (cycle 10) → busy=0 and hi=lo=0 immediately. A new MULTU 2×2 after release → lo=4.
- Build without EXEC_MULDIV_EN: MULT → illegal_op=1, busy stays 0; funct 111111 → illegal_op=1 in both builds.
